// File: rtl/cpu_datapath_if.sv
// Control word, feedback and memory bus between control_unit/memory (master) and cpu_datapath (slave).
// Pure wiring: no storage, no handshake; every field is valid each cycle.
interface cpu_datapath_if;
   logic [2:0] next_state;
   logic       pc_we;
   logic       pc_sel;
   logic       pc_jmp_sel;
   logic [3:0] pc_offset;
   logic       addr_sel;
   logic [3:0] addr_offset;
   logic       mem_sel;
   logic       mem_we;
   logic [2:0] alu_opcode;
   logic       alu_sel_a;
   logic       alu_sel_b;
   logic       alu_we;
   logic       zf_we;
   logic       ir_we;
   logic       a_sel;
   logic       b_sel;
   logic       a_we;
   logic       b_we;
   logic       halt;
   logic [7:0] instr;
   logic [2:0] state;
   logic       zf;
   logic [7:0] mem_addr;
   logic [7:0] mem_wdata;
   logic       mem_wr;
   logic [7:0] mem_rdata;
   logic       halted;

   modport master (
      output next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset, addr_sel, addr_offset,
             mem_sel, mem_we, alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we,
             a_sel, b_sel, a_we, b_we, halt, mem_rdata,
      input  instr, state, zf, mem_addr, mem_wdata, mem_wr, halted
   );

   modport slave (
      input  next_state, pc_we, pc_sel, pc_jmp_sel, pc_offset, addr_sel, addr_offset,
             mem_sel, mem_we, alu_opcode, alu_sel_a, alu_sel_b, alu_we, zf_we, ir_we,
             a_sel, b_sel, a_we, b_we, halt, mem_rdata,
      output instr, state, zf, mem_addr, mem_wdata, mem_wr, halted
   );
endinterface

// File: rtl/cpu_datapath.sv
// 8-bit CPU datapath: PC, IR, A, B, ALU result, zero flag and FSM state, driven by control_unit.
// Register updates take one clk edge; memory address/data are combinational; no backpressure.
module cpu_datapath #(
   parameter logic [7:0] PC_RESET    = 8'h00,
   parameter logic [2:0] STATE_RESET = 3'b000
) (
   input  logic          clk,
   input  logic          reset,
   cpu_datapath_if.slave bus
);

   logic [7:0] pc_q, pc_d;
   logic [7:0] ir_q, ir_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [7:0] alu_out_q, alu_out_d;
   logic       zf_q, zf_d;
   logic [2:0] state_q, state_d;
   logic       halted_q, halted_d;

   logic       upd;
   logic [7:0] op_a, op_b, alu_res, jmp_base;

   // An edge that samples halt, or any edge after it, leaves the architectural state alone.
   assign upd = ~bus.halt & ~halted_q;

   always_comb begin
      op_a    = bus.alu_sel_a ? b_q : a_q;
      op_b    = bus.alu_sel_b ? b_q : a_q;
      alu_res = op_a;
      case (bus.alu_opcode)
         3'b000:  alu_res = op_a + op_b;
         3'b001:  alu_res = op_a & op_b;
         3'b010:  alu_res = ~op_a;
         default: alu_res = op_a;
      endcase
   end

   assign jmp_base = bus.pc_jmp_sel ? b_q : a_q;

   always_comb begin
      pc_d      = pc_q;
      ir_d      = ir_q;
      a_d       = a_q;
      b_d       = b_q;
      alu_out_d = alu_out_q;
      zf_d      = zf_q;
      state_d   = state_q;
      halted_d  = halted_q | bus.halt;
      if (upd) begin
         state_d = bus.next_state;
         if (bus.pc_we)
            pc_d = bus.pc_sel ? (jmp_base + {4'b0000, bus.pc_offset}) : (pc_q + 8'h01);
         if (bus.ir_we)
            ir_d = bus.mem_rdata;
         // Writeback reads alu_out_q, so a same-cycle alu_we does not forward.
         if (bus.a_we)
            a_d = bus.a_sel ? bus.mem_rdata : alu_out_q;
         if (bus.b_we)
            b_d = bus.b_sel ? bus.mem_rdata : alu_out_q;
         if (bus.alu_we)
            alu_out_d = alu_res;
         if (bus.zf_we)
            zf_d = (alu_res == 8'h00);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q      <= PC_RESET;
         ir_q      <= 8'h00;
         a_q       <= 8'h00;
         b_q       <= 8'h00;
         alu_out_q <= 8'h00;
         zf_q      <= 1'b0;
         state_q   <= STATE_RESET;
         halted_q  <= 1'b0;
      end else begin
         pc_q      <= pc_d;
         ir_q      <= ir_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         zf_q      <= zf_d;
         state_q   <= state_d;
         halted_q  <= halted_d;
      end
   end

   assign bus.instr     = ir_q;
   assign bus.state     = state_q;
   assign bus.zf        = zf_q;
   assign bus.halted    = halted_q;
   assign bus.mem_addr  = bus.addr_sel ? (a_q + {4'b0000, bus.addr_offset}) : pc_q;
   assign bus.mem_wdata = bus.mem_sel ? b_q : a_q;
   assign bus.mem_wr    = bus.mem_we & ~halted_q;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed-vector bench for cpu_datapath; internal registers are observed through mem_addr/mem_wdata.
module tb_cpu_datapath;
   logic clk;
   logic reset;
   int   errors;
   int   checks;

   cpu_datapath_if bus ();

   cpu_datapath #(.PC_RESET(8'h00), .STATE_RESET(3'b000)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_ctl();
      bus.pc_we = 0; bus.pc_sel = 0; bus.pc_jmp_sel = 0; bus.pc_offset = 0;
      bus.addr_sel = 0; bus.addr_offset = 0; bus.mem_sel = 0; bus.mem_we = 0;
      bus.alu_opcode = 0; bus.alu_sel_a = 0; bus.alu_sel_b = 0; bus.alu_we = 0;
      bus.zf_we = 0; bus.ir_we = 0; bus.a_sel = 0; bus.b_sel = 0;
      bus.a_we = 0; bus.b_we = 0; bus.halt = 0;
   endtask

   task automatic load_a(input logic [7:0] v);
      clear_ctl();
      bus.mem_rdata = v; bus.a_sel = 1; bus.a_we = 1;
      tick();
      clear_ctl();
   endtask

   task automatic load_b(input logic [7:0] v);
      clear_ctl();
      bus.mem_rdata = v; bus.b_sel = 1; bus.b_we = 1;
      tick();
      clear_ctl();
   endtask

   task automatic test_reset();
      reset = 0;
      clear_ctl();
      bus.next_state = 3'b001; bus.mem_rdata = 8'h14; bus.ir_we = 1;
      #2;
      checks++; if (bus.instr !== 8'h00) begin errors++; $display("FAIL reset_instr: got %h want 00", bus.instr); end
      checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b want 000", bus.state); end
      checks++; if (bus.zf !== 1'b0) begin errors++; $display("FAIL reset_zf: got %b want 0", bus.zf); end
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %b want 0", bus.halted); end
      checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_a: got %h want 00", bus.mem_wdata); end
      bus.mem_sel = 1; #1;
      checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_b: got %h want 00", bus.mem_wdata); end
      bus.mem_sel = 0;
      repeat (2) tick();
      checks++; if (bus.instr !== 8'h00) begin errors++; $display("FAIL reset_hold_ir: got %h want 00", bus.instr); end
      reset = 1;
      tick();
      checks++; if (bus.instr !== 8'h14) begin errors++; $display("FAIL ir_load: got %h want 14", bus.instr); end
      checks++; if (bus.state !== 3'b001) begin errors++; $display("FAIL state_follow: got %b want 001", bus.state); end
      clear_ctl();
   endtask

   task automatic test_alu_add();
      load_a(8'h03);
      load_b(8'h05);
      bus.alu_opcode = 3'b000; bus.alu_sel_a = 0; bus.alu_sel_b = 1; bus.alu_we = 1; bus.zf_we = 1;
      tick();
      checks++; if (bus.zf !== 1'b0) begin errors++; $display("FAIL add_zf: got %b want 0", bus.zf); end
      clear_ctl();
      bus.a_we = 1; bus.a_sel = 0;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.mem_wdata !== 8'h08) begin errors++; $display("FAIL add_wb_a: got %h want 08", bus.mem_wdata); end
   endtask

   task automatic test_zero_flag();
      load_a(8'hFF);
      load_b(8'h01);
      // ADD wraps to zero; A picks up the previous alu_out (8) on the same edge.
      bus.alu_opcode = 3'b000; bus.alu_sel_b = 1; bus.alu_we = 1; bus.zf_we = 1; bus.a_we = 1;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.zf !== 1'b1) begin errors++; $display("FAIL add_wrap_zf: got %b want 1", bus.zf); end
      checks++; if (bus.mem_wdata !== 8'h08) begin errors++; $display("FAIL wb_old_alu: got %h want 08", bus.mem_wdata); end
      load_a(8'hFF);
      // AND FF&01=01 with zf_we only: zf tracks this result while alu_out stays 00.
      bus.alu_opcode = 3'b001; bus.alu_sel_b = 1; bus.zf_we = 1;
      tick();
      clear_ctl();
      checks++; if (bus.zf !== 1'b0) begin errors++; $display("FAIL and_zf: got %b want 0", bus.zf); end
      bus.alu_opcode = 3'b010; bus.alu_we = 1; bus.zf_we = 1;
      tick();
      clear_ctl();
      checks++; if (bus.zf !== 1'b1) begin errors++; $display("FAIL not_ff_zf: got %b want 1", bus.zf); end
      load_a(8'h0F);
      bus.alu_opcode = 3'b010; bus.alu_we = 1; bus.zf_we = 1;
      tick();
      clear_ctl();
      checks++; if (bus.zf !== 1'b0) begin errors++; $display("FAIL not_0f_zf: got %b want 0", bus.zf); end
      bus.a_we = 1;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.mem_wdata !== 8'hF0) begin errors++; $display("FAIL not_result: got %h want F0", bus.mem_wdata); end
      bus.alu_opcode = 3'b101; bus.alu_sel_a = 1; bus.alu_we = 1;
      tick();
      clear_ctl();
      bus.a_we = 1;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.mem_wdata !== 8'h01) begin errors++; $display("FAIL pass_b: got %h want 01", bus.mem_wdata); end
   endtask

   task automatic test_pc();
      load_b(8'hFE);
      bus.pc_we = 1; bus.pc_sel = 1; bus.pc_jmp_sel = 1; bus.pc_offset = 4'd5;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.mem_addr !== 8'h03) begin errors++; $display("FAIL jmp_b_wrap: got %h want 03", bus.mem_addr); end
      load_a(8'hFA);
      bus.pc_we = 1; bus.pc_sel = 1; bus.pc_jmp_sel = 0; bus.pc_offset = 4'd5;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.mem_addr !== 8'hFF) begin errors++; $display("FAIL jmp_a: got %h want FF", bus.mem_addr); end
      bus.pc_we = 1; bus.pc_sel = 0;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL pc_inc_wrap: got %h want 00", bus.mem_addr); end
   endtask

   task automatic test_mem();
      load_a(8'h10);
      load_b(8'h77);
      bus.addr_sel = 1; bus.addr_offset = 4'd4; bus.mem_sel = 1; bus.mem_we = 1;
      #1;
      checks++; if (bus.mem_addr !== 8'h14) begin errors++; $display("FAIL data_addr: got %h want 14", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 8'h77) begin errors++; $display("FAIL wdata_b: got %h want 77", bus.mem_wdata); end
      checks++; if (bus.mem_wr !== 1'b1) begin errors++; $display("FAIL mem_wr: got %b want 1", bus.mem_wr); end
      bus.mem_sel = 0; #1;
      checks++; if (bus.mem_wdata !== 8'h10) begin errors++; $display("FAIL wdata_a: got %h want 10", bus.mem_wdata); end
      load_a(8'hFE);
      bus.addr_sel = 1; bus.addr_offset = 4'hF; #1;
      checks++; if (bus.mem_addr !== 8'h0D) begin errors++; $display("FAIL data_addr_wrap: got %h want 0D", bus.mem_addr); end
      clear_ctl();
   endtask

   task automatic test_back_to_back();
      bus.mem_rdata = 8'h5A; bus.a_sel = 1; bus.b_sel = 1; bus.a_we = 1; bus.b_we = 1;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.mem_wdata !== 8'h5A) begin errors++; $display("FAIL dual_a: got %h want 5A", bus.mem_wdata); end
      bus.mem_sel = 1; #1;
      checks++; if (bus.mem_wdata !== 8'h5A) begin errors++; $display("FAIL dual_b: got %h want 5A", bus.mem_wdata); end
      clear_ctl();
   endtask

   task automatic test_halt();
      bus.pc_we = 1; bus.next_state = 3'b010;
      tick();
      clear_ctl(); #1;
      checks++; if (bus.state !== 3'b010) begin errors++; $display("FAIL state_2: got %b want 010", bus.state); end
      checks++; if (bus.mem_addr !== 8'h01) begin errors++; $display("FAIL pc_pre_halt: got %h want 01", bus.mem_addr); end
      bus.halt = 1; bus.pc_we = 1; bus.mem_we = 1; bus.a_we = 1; bus.a_sel = 1;
      bus.mem_rdata = 8'h33; bus.next_state = 3'b101;
      tick();
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halted_set: got %b want 1", bus.halted); end
      checks++; if (bus.state !== 3'b010) begin errors++; $display("FAIL halt_state: got %b want 010", bus.state); end
      checks++; if (bus.mem_wr !== 1'b0) begin errors++; $display("FAIL halt_mem_wr: got %b want 0", bus.mem_wr); end
      checks++; if (bus.mem_addr !== 8'h01) begin errors++; $display("FAIL halt_pc: got %h want 01", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 8'h5A) begin errors++; $display("FAIL halt_a: got %h want 5A", bus.mem_wdata); end
      bus.halt = 0;
      tick();
      checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL halted_sticky: got %b want 1", bus.halted); end
      checks++; if (bus.mem_addr !== 8'h01) begin errors++; $display("FAIL halted_pc: got %h want 01", bus.mem_addr); end
      #2;
      reset = 0;
      #1;
      checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL async_halted: got %b want 0", bus.halted); end
      checks++; if (bus.state !== 3'b000) begin errors++; $display("FAIL async_state: got %b want 000", bus.state); end
      checks++; if (bus.instr !== 8'h00) begin errors++; $display("FAIL async_instr: got %h want 00", bus.instr); end
      checks++; if (bus.mem_addr !== 8'h00) begin errors++; $display("FAIL async_pc: got %h want 00", bus.mem_addr); end
      checks++; if (bus.mem_wdata !== 8'h00) begin errors++; $display("FAIL async_a: got %h want 00", bus.mem_wdata); end
      clear_ctl();
      tick();
      reset = 1;
   endtask

   initial begin
      errors = 0;
      checks = 0;
      bus.next_state = 3'b000;
      bus.mem_rdata  = 8'h00;
      test_reset();
      test_alu_add();
      test_zero_flag();
      test_pc();
      test_mem();
      test_back_to_back();
      test_halt();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
